// File: rtl/adc_sample_scheduler.sv
// adc_sample_scheduler
//   Walks the modular ADC control core through a channel scan list once per
//   frame tick. It issues one Avalon-ST command at a time, waits for the
//   matching response and forwards it as a one-cycle sample strobe.
//   Optional response watchdog: define ADC_SCHED_TIMEOUT_EN.
module adc_sample_scheduler #(
    parameter int unsigned CLK_DIV     = 208,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic        clk_adc_clk,
    input  logic        reset_reset_n,
    input  logic        enable,
    input  logic [16:0] chan_mask,
    input  logic        clr_status,
    output logic        cmd_valid,
    output logic [4:0]  cmd_channel,
    output logic        cmd_sop,
    output logic        cmd_eop,
    input  logic        cmd_ready,
    input  logic        rsp_valid,
    input  logic [4:0]  rsp_channel,
    input  logic [11:0] rsp_data,
    output logic        smp_valid,
    output logic [4:0]  smp_channel,
    output logic [11:0] smp_data,
    output logic        smp_frame_end,
    output logic        busy,
    output logic [7:0]  overrun_cnt,
    output logic        mismatch,
    output logic        timeout
);

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP} state_t;

    state_t      state;
    logic [15:0] tick_cnt;
    logic        tick;
    logic [16:0] mask_q;
    logic [4:0]  cur_ch;

    // Lowest set bit of a channel mask (0 when the mask is empty).
    function automatic logic [4:0] lowest_bit(input logic [16:0] m);
        lowest_bit = 5'd0;
        for (int i = 16; i >= 0; i--) begin
            if (m[i]) lowest_bit = 5'(i);
        end
    endfunction

    // Bits of m strictly above channel c.
    function automatic logic [16:0] bits_above(input logic [16:0] m, input logic [4:0] c);
        bits_above = '0;
        for (int i = 0; i < 17; i++) begin
            if (m[i] && (5'(i) > c)) bits_above[i] = 1'b1;
        end
    endfunction

    // Scan-list decode: first channel of a new frame and the successor of
    // the current channel within the mask latched at frame start.
    logic [4:0]  first_ch;
    logic        first_last;
    logic [16:0] above;
    logic        more;
    logic [4:0]  next_ch;
    logic        next_last;

    assign first_ch   = lowest_bit(chan_mask);
    assign first_last = (bits_above(chan_mask, first_ch) == 17'd0);
    assign above      = bits_above(mask_q, cur_ch);
    assign more       = |above;
    assign next_ch    = lowest_bit(above);
    assign next_last  = (bits_above(mask_q, next_ch) == 17'd0);

    assign tick = enable && (tick_cnt == DIV_LAST);

    // Status set events; a set beats clr_status in the same cycle.
    logic mm_set;
    logic ov_set;
    assign mm_set = rsp_valid && ((state != WAIT_RESP) || (rsp_channel != cur_ch));
    assign ov_set = tick && busy;

`ifdef ADC_SCHED_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

    logic [WD_W-1:0] wd_cnt;
    logic            wd_fire;
    assign wd_fire = (state == WAIT_RESP) && !rsp_valid && (wd_cnt == WD_LAST);
`endif

    // Frame-rate divider: free-runs while enabled, parked at 0 otherwise.
    always_ff @(posedge clk_adc_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            tick_cnt <= 16'd0;
        end else if (!enable || tick) begin
            tick_cnt <= 16'd0;
        end else begin
            tick_cnt <= tick_cnt + 16'd1;
        end
    end

    // Scan FSM: one outstanding command, registered command/sample outputs.
    always_ff @(posedge clk_adc_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state         <= IDLE;
            mask_q        <= '0;
            cur_ch        <= '0;
            busy          <= 1'b0;
            cmd_valid     <= 1'b0;
            cmd_channel   <= '0;
            cmd_sop       <= 1'b0;
            cmd_eop       <= 1'b0;
            smp_valid     <= 1'b0;
            smp_channel   <= '0;
            smp_data      <= '0;
            smp_frame_end <= 1'b0;
`ifdef ADC_SCHED_TIMEOUT_EN
            wd_cnt        <= '0;
`endif
        end else begin
            smp_valid     <= 1'b0;
            smp_frame_end <= 1'b0;
            case (state)
                IDLE: begin
                    if (tick && (chan_mask != 17'd0)) begin
                        mask_q      <= chan_mask;
                        cur_ch      <= first_ch;
                        busy        <= 1'b1;
                        cmd_valid   <= 1'b1;
                        cmd_channel <= first_ch;
                        cmd_sop     <= 1'b1;
                        cmd_eop     <= first_last;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Command fields stay frozen until the core accepts.
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        cmd_sop   <= 1'b0;
                        cmd_eop   <= 1'b0;
                        state     <= WAIT_RESP;
`ifdef ADC_SCHED_TIMEOUT_EN
                        wd_cnt    <= '0;
`endif
                    end
                end
                WAIT_RESP: begin
                    if (rsp_valid) begin
                        // Forward what the ADC returned, even on a channel mismatch.
                        smp_valid   <= 1'b1;
                        smp_channel <= rsp_channel;
                        smp_data    <= rsp_data;
                        if (more) begin
                            cur_ch      <= next_ch;
                            cmd_valid   <= 1'b1;
                            cmd_channel <= next_ch;
                            cmd_sop     <= 1'b0;
                            cmd_eop     <= next_last;
                            state       <= ISSUE;
                        end else begin
                            smp_frame_end <= 1'b1;
                            busy          <= 1'b0;
                            state         <= IDLE;
                        end
                    end
`ifdef ADC_SCHED_TIMEOUT_EN
                    else if (wd_fire) begin
                        // Silent ADC: drop the rest of the frame, no sample.
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sticky status flags and saturating overrun counter.
    always_ff @(posedge clk_adc_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            overrun_cnt <= 8'd0;
            mismatch    <= 1'b0;
        end else begin
            if (ov_set) begin
                if (overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 8'd1;
            end else if (clr_status) begin
                overrun_cnt <= 8'd0;
            end
            if (mm_set) begin
                mismatch <= 1'b1;
            end else if (clr_status) begin
                mismatch <= 1'b0;
            end
        end
    end

`ifdef ADC_SCHED_TIMEOUT_EN
    // Sticky watchdog flag.
    always_ff @(posedge clk_adc_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            timeout <= 1'b0;
        end else if (wd_fire) begin
            timeout <= 1'b1;
        end else if (clr_status) begin
            timeout <= 1'b0;
        end
    end
`else
    assign timeout = 1'b0;
`endif

endmodule
